mixop_arbiter: RTL and testbench



---
 rtl/mixop_arbiter.sv | 109 ++++++++++
 tb/tb_mixop_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixop_arbiter.sv
// Round-robin arbiter in front of one shared mixed-arithmetic operator.
// The winner's operands are captured, evaluated once, and returned on a valid/ready port.
module mixop_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [14:0] op0,
  input  logic [1:0]  mode0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [14:0] op1,
  input  logic [1:0]  mode1,
  output logic        gnt1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t      state;
  logic        ptr;
  logic        win;
  logic        pick;
  logic [14:0] op_q;
  logic [1:0]  mode_q;
  logic [7:0]  a, b, c, d, e;
  logic [7:0]  m1, m2, m3, m4, res;

  // ptr only matters when both requesters are asking
  always_comb begin
    pick = ptr;
    if (req0 && !req1) pick = 1'b0;
    else if (req1 && !req0) pick = 1'b1;
  end

  assign a = {5'd0, op_q[14:12]};
  assign b = {5'd0, op_q[11:9]};
  assign c = {5'd0, op_q[8:6]};
  assign d = {5'd0, op_q[5:3]};
  assign e = {5'd0, op_q[2:0]};

  assign m1 = (a + b) * (c + d);
  assign m2 = a * c + b * d;
  assign m3 = ((a ^ b) + d) * (e & 8'd1);
  assign m4 = (m1 + m2) ^ (m3 >> 2);

  always_comb begin
    res = m1;
    unique case (mode_q)
      2'b00: res = m1;
      2'b01: res = m2;
      2'b10: res = m3;
      2'b11: res = m4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= RR_INIT;
      win       <= 1'b0;
      op_q      <= '0;
      mode_q    <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            win    <= pick;
            ptr    <= ~pick;
            op_q   <= pick ? op1 : op0;
            mode_q <= pick ? mode1 : mode0;
            gnt0   <= ~pick;
            gnt1   <= pick;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_data  <= res;
          rsp_id    <= win;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mixop_arbiter.sv
// Bench for mixop_arbiter: vector table, scoreboard monitor, and
// hand-written sequences for contention, back-pressure and mid-op reset.
module tb_mixop_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, rsp_ready = 1'b1;
  logic [14:0] op0 = '0, op1 = '0;
  logic [1:0]  mode0 = '0, mode1 = '0;
  logic        gnt0, gnt1, rsp_valid, rsp_id, busy;
  logic [7:0]  rsp_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic        id;
    logic [14:0] op;
    logic [1:0]  mode;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
  } rsp_t;

  rsp_t sb[$];
  vec_t vt[8];

  mixop_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .mode0(mode0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .mode1(mode1), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] mkop(int a, int b, int c, int d, int e);
    logic [2:0] fa, fb, fc, fd, fe;
    fa = 3'(a); fb = 3'(b); fc = 3'(c); fd = 3'(d); fe = 3'(e);
    return {fa, fb, fc, fd, fe};
  endfunction

  function automatic logic [7:0] model(logic [14:0] op, logic [1:0] mode);
    int a, b, c, d, e, m1, m2, m3, m4;
    a = int'(op[14:12]); b = int'(op[11:9]); c = int'(op[8:6]);
    d = int'(op[5:3]);   e = int'(op[2:0]);
    m1 = ((a + b) * (c + d)) % 256;
    m2 = (a * c + b * d) % 256;
    m3 = (((a ^ b) + d) * (e % 2)) % 256;
    m4 = ((m1 + m2) % 256) ^ (m3 / 4);
    case (mode)
      2'b00: return 8'(m1);
      2'b01: return 8'(m2);
      2'b10: return 8'(m3);
      default: return 8'(m4);
    endcase
  endfunction

  // Scoreboard and invariant monitor
  always @(negedge clk) begin
    rsp_t x;
    if (gnt0 || gnt1) begin
      check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 0);
      check("gnt_busy", {31'd0, busy}, 1);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0d, required none",
                 rsp_id, rsp_data);
      end else begin
        x = sb.pop_front();
        check("rsp_id", {31'd0, rsp_id}, {31'd0, x.id});
        check("rsp_data", {24'd0, rsp_data}, {24'd0, x.data});
      end
    end
  end

  task automatic start_req(logic id, logic [14:0] op, logic [1:0] mode);
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; op1 = op; mode1 = mode; end
    else begin req0 = 1'b1; op0 = op; mode0 = mode; end
  endtask

  task automatic drop_req(logic id);
    if (id) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  task automatic wait_gnt(logic id, string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(id ? gnt1 : gnt0) && n < 20);
    check(name, n, 2);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 0);
  endtask

  task automatic txn(logic id, logic [14:0] op, logic [1:0] mode,
                     logic [7:0] exp, string name);
    sb.push_back('{id, exp});
    start_req(id, op, mode);
    wait_gnt(id, {name, "_gnt_lat"});
    check({name, "_busy_calc"}, {31'd0, busy}, 1);
    @(posedge clk); #1;
    drop_req(id);
    @(negedge clk);
    check({name, "_valid_t2"}, {30'd0, rsp_valid, gnt0 | gnt1}, 2);
    @(negedge clk);
    check({name, "_idle_t3"}, {30'd0, busy, rsp_valid}, 0);
  endtask

  initial begin
    int n, last;
    logic [14:0] rop;
    logic [1:0]  rmode;
    logic [7:0]  bp_exp;

    vt[0] = '{1'b0, mkop(3, 2, 1, 4, 5), 2'b11, 8'd37};
    vt[1] = '{1'b1, mkop(7, 7, 7, 7, 7), 2'b00, 8'd196};
    vt[2] = '{1'b0, mkop(7, 7, 7, 7, 7), 2'b01, 8'd98};
    vt[3] = '{1'b1, mkop(7, 7, 7, 7, 7), 2'b10, 8'd7};
    vt[4] = '{1'b0, mkop(7, 7, 7, 7, 7), 2'b11, 8'd39};
    vt[5] = '{1'b1, mkop(5, 1, 0, 6, 6), 2'b10, 8'd0};
    vt[6] = '{1'b0, mkop(5, 1, 0, 6, 3), 2'b10, 8'd10};
    vt[7] = '{1'b1, mkop(0, 0, 0, 0, 0), 2'b11, 8'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {19'd0, gnt0, gnt1, rsp_valid, rsp_id, busy, rsp_data},
          0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      txn(vt[i].id, vt[i].op, vt[i].mode, vt[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rop = 15'($urandom);
      rmode = 2'($urandom_range(0, 3));
      txn(1'(i), rop, rmode, model(rop, rmode), $sformatf("rnd%0d", i));
    end

    // Back-pressure with operand change after grant
    rsp_ready = 1'b0;
    rop = mkop(6, 5, 4, 3, 1);
    bp_exp = model(rop, 2'b11);
    sb.push_back('{1'b1, bp_exp});
    start_req(1'b1, rop, 2'b11);
    wait_gnt(1'b1, "bp_gnt_lat");
    @(posedge clk); #1;
    req1 = 1'b0;
    op1 = mkop(1, 1, 1, 1, 0);
    mode1 = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {23'd0, rsp_valid, rsp_data}, {23'd1, bp_exp});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after_ready", {31'd0, busy}, 0);

    // Reset during CALC of a requester-0 transaction (ptr would become 1)
    start_req(1'b0, mkop(2, 2, 2, 2, 2), 2'b00);
    wait_gnt(1'b0, "rcalc_gnt_lat");
    rst_n = 1'b0;
    req0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rcalc_after", {30'd0, rsp_valid, busy}, 0);
    repeat (3) begin
      @(negedge clk);
      check("rcalc_no_stale", {31'd0, rsp_valid}, 0);
    end

    // Reset during RESP while the consumer is stalling
    rsp_ready = 1'b0;
    start_req(1'b0, mkop(3, 3, 3, 3, 3), 2'b01);
    wait_gnt(1'b0, "rresp_gnt_lat");
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("rresp_valid", {31'd0, rsp_valid}, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rresp_after", {30'd0, rsp_valid, busy}, 0);
    repeat (3) begin
      @(negedge clk);
      check("rresp_no_stale", {31'd0, rsp_valid}, 0);
    end

    // Contention: ptr back at RR_INIT=0, grants alternate 0,1,0,1
    rop = mkop(4, 1, 2, 5, 7);
    sb.push_back('{1'b0, model(rop, 2'b00)});
    sb.push_back('{1'b1, model(mkop(2, 6, 3, 1, 5), 2'b01)});
    sb.push_back('{1'b0, model(rop, 2'b00)});
    sb.push_back('{1'b1, model(mkop(2, 6, 3, 1, 5), 2'b01)});
    @(posedge clk); #1;
    req0 = 1'b1; op0 = rop; mode0 = 2'b00;
    req1 = 1'b1; op1 = mkop(2, 6, 3, 1, 5); mode1 = 2'b01;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(gnt0 || gnt1) && n < 20);
      check($sformatf("cont_gnt%0d_seen", k), {31'd0, gnt0 | gnt1}, 1);
      check($sformatf("cont_gnt%0d_id", k), {31'd0, gnt1}, k % 2);
      if (k > 0) check($sformatf("cont_gnt%0d_gap", k), cyc - last, 3);
      last = cyc;
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    wait_idle("cont_idle");
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
